// File: rtl/pokemon_pkg.sv
// Shared types and constants for the projectile arbiter and its stepper.
package pokemon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_OVER     = 2'd3
    } state_t;

    localparam logic OWNER_CHARMANDER = 1'b0;
    localparam logic OWNER_SQUIRTLE   = 1'b1;

    localparam logic [5:0] LANE_TOP = 6'd0;
    localparam logic [5:0] LANE_MID = 6'd18;
    localparam logic [5:0] LANE_BOT = 6'd36;

    localparam int unsigned SCREEN_W = 96;

    // HP after a resolved shot; a landed hit never takes HP below zero.
    function automatic logic [3:0] hp_after_hit(input logic [3:0] hp, input logic hit);
        return (hit && (hp != 4'd0)) ? (hp - 4'd1) : hp;
    endfunction

endpackage

// File: rtl/projectile_stepper.sv
// Projectile column register: loads the muzzle column at grant and walks
// toward the opposite muzzle by STEP per step request, clamped at the endpoint.
// dir/load_dir: 0 = Charmander (moves right), 1 = Squirtle (moves left).
module projectile_stepper
    import pokemon_pkg::*;
#(
    parameter int unsigned X_LEFT  = 16,
    parameter int unsigned X_RIGHT = 80,
    parameter int unsigned STEP    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       load_dir,
    input  logic       step,
    input  logic       dir,
    output logic [6:0] x,
    output logic       at_end
);

    localparam logic [6:0] XL7   = 7'(X_LEFT);
    localparam logic [6:0] XR7   = 7'(X_RIGHT);
    localparam logic [6:0] STEP7 = 7'(STEP);
    localparam logic [7:0] XR8   = 8'(X_RIGHT);
    localparam logic [7:0] STEP8 = 8'(STEP);
    localparam logic [7:0] BACK_LIM8 = 8'(X_LEFT + STEP);

    logic [6:0] x_q;
    logic [6:0] x_d;
    logic [7:0] x8;
    logic [7:0] fwd8;

    assign x8     = {1'b0, x_q};
    assign fwd8   = x8 + STEP8;
    assign at_end = (x_q == ((dir == OWNER_SQUIRTLE) ? XL7 : XR7));
    assign x      = x_q;

    // Next column: load at grant, otherwise clamp-step toward the endpoint.
    always_comb begin
        x_d = x_q;
        if (load) begin
            x_d = (load_dir == OWNER_SQUIRTLE) ? XR7 : XL7;
        end else if (step && !at_end) begin
            if (dir == OWNER_CHARMANDER) begin
                x_d = (fwd8 >= XR8) ? XR7 : (x_q + STEP7);
            end else begin
                x_d = (x8 <= BACK_LIM8) ? XL7 : (x_q - STEP7);
            end
        end
    end

    // Column register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/pokemon_battle_arbiter.sv
// Two-player projectile arbiter: round-robin grant, flight, hit resolution,
// HP bookkeeping and game-over detection.
// Optional feature macro: BATTLE_COOLDOWN_EN (post-shot lockout of
// COOLDOWN_TICKS move_ticks). Without it a non-fatal shot returns to IDLE.
module pokemon_battle_arbiter
    import pokemon_pkg::*;
#(
    parameter int unsigned HP_INIT        = 5,
    parameter int unsigned X_LEFT         = 16,
    parameter int unsigned X_RIGHT        = 80,
    parameter int unsigned STEP           = 4,
    parameter int unsigned COOLDOWN_TICKS = 8
) (
    input  logic       single_pulse_clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic       player1_fire,
    input  logic       player2_fire,
    input  logic [5:0] topYCharmander,
    input  logic [5:0] topYSquirtle,
    output logic       proj_active,
    output logic       proj_owner,
    output logic [6:0] proj_x,
    output logic [5:0] proj_y,
    output logic [3:0] hp_charmander,
    output logic [3:0] hp_squirtle,
    output logic       hit_pulse,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0] HP_INIT4 = 4'(HP_INIT);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [5:0] y_q, y_d;
    logic       active_q, active_d;
    logic [3:0] hpc_q, hpc_d;
    logic [3:0] hps_q, hps_d;
    logic       hit_q, hit_d;
    logic       over_q, over_d;
    logic       winner_q, winner_d;
    logic       last_q, last_d;
`ifdef BATTLE_COOLDOWN_EN
    localparam logic [7:0] CD_LAST = 8'(COOLDOWN_TICKS - 1);
    logic [7:0] cd_q, cd_d;
`endif

    logic       any_fire;
    logic       grantee;
    logic       lane_hit;
    logic [3:0] target_hp;
    logic [3:0] new_hp;
    logic       stp_load;
    logic       stp_step;
    logic       at_end;

    projectile_stepper #(
        .X_LEFT (X_LEFT),
        .X_RIGHT(X_RIGHT),
        .STEP   (STEP)
    ) u_stepper (
        .clk     (single_pulse_clk),
        .rst     (reset),
        .load    (stp_load),
        .load_dir(grantee),
        .step    (stp_step),
        .dir     (owner_q),
        .x       (proj_x),
        .at_end  (at_end)
    );

    // Arbitration and resolution helpers, shared by the FSM below.
    always_comb begin
        any_fire  = player1_fire | player2_fire;
        grantee   = (player1_fire && player2_fire) ? ~last_q : player2_fire;
        lane_hit  = (owner_q == OWNER_CHARMANDER) ? (y_q == topYSquirtle)
                                                  : (y_q == topYCharmander);
        target_hp = (owner_q == OWNER_CHARMANDER) ? hps_q : hpc_q;
        new_hp    = hp_after_hit(target_hp, lane_hit);
    end

    // Next-state and datapath control for grant / flight / cooldown / over.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        y_d      = y_q;
        active_d = active_q;
        hpc_d    = hpc_q;
        hps_d    = hps_q;
        hit_d    = 1'b0;
        over_d   = over_q;
        winner_d = winner_q;
        last_d   = last_q;
        stp_load = 1'b0;
        stp_step = 1'b0;
`ifdef BATTLE_COOLDOWN_EN
        cd_d     = cd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_fire) begin
                    owner_d  = grantee;
                    y_d      = (grantee == OWNER_SQUIRTLE) ? topYSquirtle : topYCharmander;
                    last_d   = grantee;
                    active_d = 1'b1;
                    stp_load = 1'b1;
                    state_d  = ST_FLY;
                end
            end
            ST_FLY: begin
                if (move_tick) begin
                    if (!at_end) begin
                        stp_step = 1'b1;
                    end else begin
                        active_d = 1'b0;
                        hit_d    = lane_hit;
                        if (owner_q == OWNER_CHARMANDER) begin
                            hps_d = new_hp;
                        end else begin
                            hpc_d = new_hp;
                        end
                        if (new_hp == 4'd0) begin
                            state_d  = ST_OVER;
                            over_d   = 1'b1;
                            winner_d = owner_q;
                        end else begin
`ifdef BATTLE_COOLDOWN_EN
                            state_d = ST_COOLDOWN;
                            cd_d    = '0;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
            end
`ifdef BATTLE_COOLDOWN_EN
            ST_COOLDOWN: begin
                if (move_tick) begin
                    if (cd_q == CD_LAST) begin
                        state_d = ST_IDLE;
                        cd_d    = '0;
                    end else begin
                        cd_d = cd_q + 8'd1;
                    end
                end
            end
`endif
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge single_pulse_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_CHARMANDER;
            y_q      <= '0;
            active_q <= 1'b0;
            hpc_q    <= HP_INIT4;
            hps_q    <= HP_INIT4;
            hit_q    <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
`ifdef BATTLE_COOLDOWN_EN
            cd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            y_q      <= y_d;
            active_q <= active_d;
            hpc_q    <= hpc_d;
            hps_q    <= hps_d;
            hit_q    <= hit_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            last_q   <= last_d;
`ifdef BATTLE_COOLDOWN_EN
            cd_q     <= cd_d;
`endif
        end
    end

    assign proj_active   = active_q;
    assign proj_owner    = owner_q;
    assign proj_y        = y_q;
    assign hp_charmander = hpc_q;
    assign hp_squirtle   = hps_q;
    assign hit_pulse     = hit_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule
